// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master sequencer: START -> CS setup -> DATA_W bits -> CS hold -> DONE pulse.
// Define SPI_LSB_FIRST_EN for LSB-first shifting; the default build is MSB-first.
module spi_master_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              START,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              MISO,
  output logic              SCLK,
  output logic              MOSI,
  output logic              CS_N,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] RX_DATA
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0]    DIV_ONE  = 8'd1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t            state;
  logic [7:0]        div;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state   <= IDLE;
      div     <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      SCLK    <= 1'b0;
      MOSI    <= 1'b0;
      CS_N    <= 1'b1;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      RX_DATA <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            tx_sh   <= TX_DATA;
            CS_N    <= 1'b0;
            BUSY    <= 1'b1;
`ifdef SPI_LSB_FIRST_EN
            MOSI    <= TX_DATA[0];
`else
            MOSI    <= TX_DATA[DATA_W-1];
`endif
            div     <= '0;
            bit_cnt <= '0;
            state   <= LEAD;
          end
        end

        LEAD: begin
          if (div == DIV_LAST) begin
            div   <= '0;
            state <= XFER;
          end else begin
            div <= div + DIV_ONE;
          end
        end

        // Each divider wrap toggles SCLK: rising edges sample MISO, falling edges advance MOSI.
        XFER: begin
          if (div == DIV_LAST) begin
            div  <= '0;
            SCLK <= ~SCLK;
            if (!SCLK) begin
`ifdef SPI_LSB_FIRST_EN
              rx_sh <= {MISO, rx_sh[DATA_W-1:1]};
`else
              rx_sh <= {rx_sh[DATA_W-2:0], MISO};
`endif
            end else begin
              bit_cnt <= bit_cnt + BIT_ONE;
              if (bit_cnt == BIT_LAST) begin
                state <= TRAIL;
              end else begin
`ifdef SPI_LSB_FIRST_EN
                tx_sh <= tx_sh >> 1;
                MOSI  <= tx_sh[1];
`else
                tx_sh <= tx_sh << 1;
                MOSI  <= tx_sh[DATA_W-2];
`endif
              end
            end
          end else begin
            div <= div + DIV_ONE;
          end
        end

        TRAIL: begin
          if (div == DIV_LAST) begin
            div     <= '0;
            state   <= IDLE;
            CS_N    <= 1'b1;
            BUSY    <= 1'b0;
            MOSI    <= 1'b0;
            RX_DATA <= rx_sh;
            DONE    <= 1'b1;
          end else begin
            div <= div + DIV_ONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: reset, table of loopback/slave transfers, held START, mid-transfer reset.
// Edges are counted with the START-accept edge as edge 1, so DONE is expected on edge 73.
`timescale 1ns/1ps
module tb_spi_master_ctrl;

  localparam int DATA_W  = 8;
  localparam int CLK_DIV = 4;
  localparam int LATENCY = CLK_DIV * (2 * DATA_W + 2) + 1;
  localparam int CS_LOW  = CLK_DIV * (2 * DATA_W + 2);

  logic       CLK = 1'b0;
  logic       CLR, START, MISO, SCLK, MOSI, CS_N, BUSY, DONE;
  logic [7:0] TX_DATA, RX_DATA;
  logic       clk_en = 1'b0;
  logic       loopback = 1'b1;
  logic       slave_bit = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] slave_word;
    logic       loop;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
  } vec_t;

  vec_t vecs[6];

  always #5 if (clk_en) CLK = ~CLK;

  assign MISO = loopback ? MOSI : slave_bit;

  spi_master_ctrl #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
    .CLK(CLK), .CLR(CLR), .START(START), .TX_DATA(TX_DATA), .MISO(MISO),
    .SCLK(SCLK), .MOSI(MOSI), .CS_N(CS_N), .BUSY(BUSY), .DONE(DONE), .RX_DATA(RX_DATA)
  );

  // Captured MOSI bits are shifted in first-bit-first, so LSB-first builds see the word reversed.
  function automatic logic [7:0] wire_order(input logic [7:0] w);
    logic [7:0] r;
`ifdef SPI_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
`else
    r = w;
`endif
    return r;
  endfunction

  function automatic int bit_index(input int k);
`ifdef SPI_LSB_FIRST_EN
    return k;
`else
    return 7 - k;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] tx, input logic hold);
    START   = 1'b1;
    TX_DATA = tx;
    @(posedge CLK);
    #1;
    if (!hold) START = 1'b0;
  endtask

  // Called right after the accept edge; follows the transfer until DONE or the edge budget runs out.
  task automatic monitor_xfer(input logic [7:0] slave_word, input logic change_tx, input logic [7:0] new_tx,
                              output int done_edge, output int rises, output logic [7:0] mosi_bits,
                              output int cs_low, output int min_stable);
    int   stable;
    logic prev_sclk, prev_mosi;
    done_edge  = 0;
    rises      = 0;
    mosi_bits  = '0;
    cs_low     = 0;
    min_stable = 1000;
    stable     = 0;
    prev_sclk  = 1'b0;
    prev_mosi  = MOSI;
    slave_bit  = slave_word[bit_index(0)];
    for (int n = 1; n <= 300; n++) begin
      if (n > 1) begin
        @(posedge CLK);
        #1;
      end
      if (change_tx && n == 20) TX_DATA = new_tx;
      if (MOSI != prev_mosi) stable = 0;
      else stable++;
      prev_mosi = MOSI;
      if (!CS_N) cs_low++;
      if (SCLK && !prev_sclk) begin
        rises++;
        mosi_bits = {mosi_bits[6:0], MOSI};
        if (stable < min_stable) min_stable = stable;
        if (rises < 8) slave_bit = slave_word[bit_index(rises)];
      end
      prev_sclk = SCLK;
      if (DONE) begin
        done_edge = n;
        break;
      end
    end
  endtask

  task automatic check_output(input string tag, input logic [7:0] exp_mosi, input logic [7:0] exp_rx,
                              input int done_edge, input int rises, input logic [7:0] mosi_bits,
                              input int cs_low, input int min_stable);
    check({tag, " done_edge"}, done_edge, LATENCY);
    check({tag, " sclk_rises"}, rises, 8);
    check({tag, " mosi_seq"}, mosi_bits, wire_order(exp_mosi));
    check({tag, " cs_low_cycles"}, cs_low, CS_LOW);
    check({tag, " mosi_setup"}, 32'(min_stable >= CLK_DIV), 1);
    check({tag, " rx_data"}, RX_DATA, exp_rx);
    check({tag, " cs_n_at_done"}, CS_N, 1);
    check({tag, " busy_at_done"}, BUSY, 0);
  endtask

  initial begin
    int         done_edge, rises, cs_low, min_stable, done_seen;
    logic [7:0] mosi_bits;

    vecs[0] = '{tx: 8'hA5, slave_word: 8'h00, loop: 1'b1, exp_rx: 8'hA5, exp_mosi: 8'hA5};
    vecs[1] = '{tx: 8'hFF, slave_word: 8'h3C, loop: 1'b0, exp_rx: 8'h3C, exp_mosi: 8'hFF};
    vecs[2] = '{tx: 8'h00, slave_word: 8'hFF, loop: 1'b0, exp_rx: 8'hFF, exp_mosi: 8'h00};
    vecs[3] = '{tx: 8'h81, slave_word: 8'h00, loop: 1'b1, exp_rx: 8'h81, exp_mosi: 8'h81};
    vecs[4] = '{tx: 8'h01, slave_word: 8'h00, loop: 1'b1, exp_rx: 8'h01, exp_mosi: 8'h01};
    vecs[5] = '{tx: 8'h6E, slave_word: 8'h96, loop: 1'b0, exp_rx: 8'h96, exp_mosi: 8'h6E};

    CLR     = 1'b1;
    START   = 1'b0;
    TX_DATA = 8'h00;
    #20;
    check("reset sclk", SCLK, 0);
    check("reset mosi", MOSI, 0);
    check("reset cs_n", CS_N, 1);
    check("reset busy", BUSY, 0);
    check("reset done", DONE, 0);
    check("reset rx_data", RX_DATA, 8'h00);

    clk_en = 1'b1;
    #2;
    CLR = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check("idle cs_n", CS_N, 1);
    check("idle busy", BUSY, 0);
    check("idle done", DONE, 0);
    check("idle sclk", SCLK, 0);

    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      loopback = vecs[v].loop;
      apply_stimulus(vecs[v].tx, 1'b0);
      monitor_xfer(vecs[v].slave_word, 1'b0, 8'h00, done_edge, rises, mosi_bits, cs_low, min_stable);
      check_output(tag, vecs[v].exp_mosi, vecs[v].exp_rx, done_edge, rises, mosi_bits, cs_low, min_stable);
      @(posedge CLK);
      #1;
      check({tag, " done_one_cycle"}, DONE, 0);
      check({tag, " rx_hold"}, RX_DATA, vecs[v].exp_rx);
    end

    // START held high: TX_DATA changes mid-word are ignored, next word starts the edge after DONE.
    loopback = 1'b1;
    apply_stimulus(8'hA5, 1'b1);
    monitor_xfer(8'h00, 1'b1, 8'h12, done_edge, rises, mosi_bits, cs_low, min_stable);
    check_output("held1", 8'hA5, 8'hA5, done_edge, rises, mosi_bits, cs_low, min_stable);
    @(posedge CLK);
    #1;
    check("held2 accept cs_n", CS_N, 0);
    check("held2 accept busy", BUSY, 1);
    check("held2 accept done", DONE, 0);
    START = 1'b0;
    monitor_xfer(8'h00, 1'b0, 8'h00, done_edge, rises, mosi_bits, cs_low, min_stable);
    check_output("held2", 8'h12, 8'h12, done_edge, rises, mosi_bits, cs_low, min_stable);

    // Asynchronous reset in the middle of a word.
    @(posedge CLK);
    #1;
    apply_stimulus(8'hA5, 1'b0);
    repeat (29) @(posedge CLK);
    #2;
    CLR = 1'b1;
    #1;
    check("abort cs_n", CS_N, 1);
    check("abort sclk", SCLK, 0);
    check("abort busy", BUSY, 0);
    check("abort done", DONE, 0);
    check("abort rx_data", RX_DATA, 8'h00);
    @(negedge CLK);
    CLR = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK);
      #1;
      if (DONE) done_seen++;
    end
    check("abort no_done", done_seen, 0);
    check("abort rx_hold", RX_DATA, 8'h00);
    apply_stimulus(8'h5A, 1'b0);
    monitor_xfer(8'h00, 1'b0, 8'h00, done_edge, rises, mosi_bits, cs_low, min_stable);
    check_output("after_abort", 8'h5A, 8'h5A, done_edge, rises, mosi_bits, cs_low, min_stable);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d, errors %0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Single-channel SPI master sequencer, mode 0 (CPOL=0, CPHA=0), for the SPI interface. It accepts a parallel word on a START strobe and drives CS_N, SCLK and MOSI. It samples MISO into a receive shift register and returns the received word with a one-cycle DONE pulse. The block is the sequencing layer above the flip-flop-level shift storage and runs entirely in the CLK domain.

Parameters:
DATA_W, 8, bits per transfer; legal range 2..32.
CLK_DIV, 4, CLK cycles per SCLK half-period; legal range 2..255; other values are unsupported.

Ports:
CLK  input  1  system clock; all state updates on posedge.
CLR  input  1  reset, asynchronous, active-high.
START  input  1  transfer request, sampled only in IDLE.
TX_DATA  input  DATA_W  word to send, captured on the edge that accepts START.
MISO  input  1  serial data from slave; assumed already synchronised.
SCLK  output  1  SPI clock; idles low.
MOSI  output  1  serial data to slave.
CS_N  output  1  slave select, active-low.
BUSY  output  1  high from the START-accept edge until DONE.
DONE  output  1  one-CLK pulse at transfer completion.
RX_DATA  output  DATA_W  last received word; holds until the next DONE.

Behaviour:
- Reset (CLR=1, asynchronous): state=IDLE, SCLK=0, MOSI=0, CS_N=1, BUSY=0, DONE=0, RX_DATA=0, divider=0, bit counter=0. A reset mid-transfer aborts immediately with no DONE, and the first CLK edge after CLR falls is in IDLE.
- States: IDLE, LEAD, XFER, TRAIL. All outputs are registered.
- IDLE: if START=1 at a posedge, capture TX_DATA into tx shift register, set CS_N=0, BUSY=1, MOSI=TX_DATA[DATA_W-1], clear divider and bit counter, go to LEAD. DONE is forced 0 on any IDLE cycle that does not follow TRAIL.
- LEAD: CS setup. Stay CLK_DIV cycles with SCLK=0, then go to XFER.
- XFER: divider counts 0..CLK_DIV-1. At terminal count, SCLK toggles and the divider returns to 0.
  - On a rising SCLK toggle, shift MISO into the rx shift register LSB; the rx register shifts left.
  - On a falling SCLK toggle, increment the bit counter. If bits remain, shift tx left and drive the next bit on MOSI. After the DATA_W-th falling toggle, go to TRAIL with MOSI holding the last bit.
  - XFER lasts exactly 2*DATA_W*CLK_DIV cycles. SCLK ends low.
- TRAIL: CS hold. Stay CLK_DIV cycles, then on the exit edge:
  - state=IDLE, CS_N=1, BUSY=0, MOSI=0;
  - RX_DATA loads the rx shift register;
  - DONE=1 for exactly that one cycle.
- Latency: DONE rises on the (CLK_DIV*(2*DATA_W+2)+1)-th posedge after the START-accept edge. With defaults this is the 73rd edge.
- START while BUSY=1 is ignored, not queued, and TX_DATA changes are ignored.
- If START is held high continuously, a new transfer is accepted on the edge after the DONE cycle, so DONE and the next accept never coincide. CS_N deasserts for at least 1 cycle between back-to-back words.
- RX_DATA changes only on the DONE edge or on reset.

Optional Feature:
Macro SPI_LSB_FIRST_EN.
- Defined: MOSI sends TX_DATA[0] first and the tx register shifts right. Received bits enter at the rx register MSB with right shifts, so the first received bit ends up in RX_DATA[0].
- Undefined: MSB-first as described above.
- Timing, states and latency are identical in both builds.

Test Plan:
- Reset values: assert CLR with no clock running. Required: SCLK=0, MOSI=0, CS_N=1, BUSY=0, DONE=0, RX_DATA=0x00. Release CLR; all outputs stay at those values with START=0.
- Loopback, defaults (MOSI tied to MISO): START pulse with TX_DATA=0xA5.
  - Required: exactly 8 SCLK rising edges, MOSI sequence 1,0,1,0,0,1,0,1.
  - DONE on the 73rd edge after accept, RX_DATA=0xA5, CS_N low for exactly 72 cycles.
- Slave model returns 0x3C while TX_DATA=0xFF. Required: RX_DATA=0x3C and MOSI=1 for all 8 bits. Each MISO bit is sampled on an SCLK rise and only after MOSI has been stable for CLK_DIV cycles.
- START held high, TX_DATA changed to 0x12 mid-transfer. Required: the first word still sends 0xA5. The second transfer accepts on the edge after DONE and sends 0x12. CS_N is high for at least 1 cycle between words.
- CLR pulsed at cycle 30 of a transfer. Required: CS_N=1, SCLK=0, BUSY=0 asynchronously, no DONE, RX_DATA=0x00. The next START completes a normal 73-cycle transfer.
- SPI_LSB_FIRST_EN defined, loopback, TX_DATA=0x01. Required: first MOSI bit is 1 and the rest are 0; RX_DATA=0x01; latency unchanged at 73.
